// File: rtl/matrix_deconstruct_if.sv
// Request/result bus and matrix-storage read port of matrix_deconstruct.
// The slave modport is the deconstructor; the master modport is the requester plus storage.
interface matrix_deconstruct_if #(
  parameter int MAX_DIM = 128,
  parameter int DATA_W  = 32
);
  logic                              start;
  logic [7:0]                        m_dim;
  logic [7:0]                        n_dim;
  logic                              read;
  logic [7:0]                        m_addr;
  logic [7:0]                        n_addr;
  logic [DATA_W-1:0]                 matrix_entry;
  logic [MAX_DIM*MAX_DIM*DATA_W-1:0] matrix_out;
  logic                              done;
  logic                              err;

  modport master (
    output start, m_dim, n_dim, matrix_entry,
    input  read, m_addr, n_addr, matrix_out, done, err
  );

  modport slave (
    input  start, m_dim, n_dim, matrix_entry,
    output read, m_addr, n_addr, matrix_out, done, err
  );
endinterface

// File: rtl/matrix_deconstruct.sv
// Streams an M x N matrix out of synchronous storage, one entry per clock,
// into a flat row-major bus: entry m*n_dim+n sits at bits [DATA_W*i +: DATA_W].
module matrix_deconstruct #(
  parameter int MAX_DIM = 128,
  parameter int DATA_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  matrix_deconstruct_if.slave  bus,
  output logic                 q_Idle,
  output logic                 q_Read,
  output logic                 q_Drain,
  output logic                 q_Done
);
  localparam int         SLOTS     = MAX_DIM * MAX_DIM;
  localparam logic [8:0] MAX_DIM_9 = 9'(MAX_DIM);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0]                    m_lat;
  logic [7:0]                    n_lat;
  logic [7:0]                    m_cnt;
  logic [7:0]                    n_cnt;
  logic [15:0]                   lin_idx;
  logic                          cap_valid;
  logic [15:0]                   cap_idx;
  logic [SLOTS-1:0][DATA_W-1:0]  slots;
  logic                          err_q;
  logic                          dims_ok;
  logic                          accept;
  logic                          n_last;
  logic                          last_issue;

  // Zero in either dimension, or anything above MAX_DIM, is rejected without touching storage.
  assign dims_ok = (bus.m_dim != 8'd0) && (bus.n_dim != 8'd0) &&
                   ({1'b0, bus.m_dim} <= MAX_DIM_9) &&
                   ({1'b0, bus.n_dim} <= MAX_DIM_9);

  assign accept     = (state == IDLE) && bus.start;
  assign n_last     = (n_cnt == n_lat - 8'd1);
  assign last_issue = n_last && (m_cnt == m_lat - 8'd1);
  assign lin_idx    = 16'(m_cnt) * 16'(n_lat) + 16'(n_cnt);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    bus.read   = 1'b0;
    bus.done   = 1'b0;
    q_Idle     = 1'b0;
    q_Read     = 1'b0;
    q_Drain    = 1'b0;
    q_Done     = 1'b0;
    case (state)
      IDLE: begin
        q_Idle = 1'b1;
        if (bus.start) begin
          next_state = dims_ok ? READ : DONE;
        end
      end
      READ: begin
        q_Read   = 1'b1;
        bus.read = 1'b1;
        if (last_issue) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        q_Drain    = 1'b1;
        next_state = DONE;
      end
      DONE: begin
        q_Done     = 1'b1;
        bus.done   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Addresses read as zero whenever no read is being issued.
  assign bus.m_addr     = (state == READ) ? m_cnt : 8'd0;
  assign bus.n_addr     = (state == READ) ? n_cnt : 8'd0;
  assign bus.matrix_out = slots;
  assign bus.err        = err_q;

  // NOTE: the result slots are reset like ordinary registers because the
  // packed output must read as zero straight out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lat     <= 8'd0;
      n_lat     <= 8'd0;
      m_cnt     <= 8'd0;
      n_cnt     <= 8'd0;
      cap_valid <= 1'b0;
      cap_idx   <= 16'd0;
      slots     <= '0;
      err_q     <= 1'b0;
    end else begin
      // Storage answers one cycle after the address, so the index travels one stage behind.
      cap_valid <= (state == READ);
      cap_idx   <= lin_idx;

      if (accept) begin
        m_lat <= bus.m_dim;
        n_lat <= bus.n_dim;
        m_cnt <= 8'd0;
        n_cnt <= 8'd0;
        if (dims_ok) begin
          err_q <= 1'b0;
          slots <= '0;
        end else begin
          err_q <= 1'b1;
        end
      end else if (state == READ) begin
        if (n_last) begin
          n_cnt <= 8'd0;
          m_cnt <= m_cnt + 8'd1;
        end else begin
          n_cnt <= n_cnt + 8'd1;
        end
      end

      if (cap_valid) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (cap_idx == 16'(s)) begin
            slots[s] <= bus.matrix_entry;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_matrix_deconstruct.sv
// Scoreboard bench for matrix_deconstruct: stimulus queues expected reads and
// results, a negedge monitor pops and compares whenever read or done is seen.
module tb_matrix_deconstruct;
  localparam int MAX_DIM = 4;
  localparam int DATA_W  = 32;
  localparam int OUTW    = MAX_DIM * MAX_DIM * DATA_W;
  localparam int AW      = $clog2(MAX_DIM);

  typedef struct {
    logic [7:0] m;
    logic [7:0] n;
    int         cyc;
  } addr_t;

  typedef struct {
    logic [OUTW-1:0] out;
    logic            err;
    int              cyc;
  } result_t;

  logic clk;
  logic reset;
  logic q_idle, q_read, q_drain, q_done;
  int   cyc;
  int   n_vec;
  int   n_miss;

  addr_t   addr_q[$];
  result_t sb_q[$];

  logic [DATA_W-1:0] mem [MAX_DIM][MAX_DIM];

  matrix_deconstruct_if #(.MAX_DIM(MAX_DIM), .DATA_W(DATA_W)) bus ();

  matrix_deconstruct #(.MAX_DIM(MAX_DIM), .DATA_W(DATA_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus.slave),
    .q_Idle  (q_idle),
    .q_Read  (q_read),
    .q_Drain (q_drain),
    .q_Done  (q_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous storage model with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.read) bus.matrix_entry <= mem[bus.m_addr[AW-1:0]][bus.n_addr[AW-1:0]];
  end

  task automatic check(input string name, input logic [OUTW-1:0] act, input logic [OUTW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: decoupled from stimulus, compares whatever the DUT presents.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.read) begin
        if (addr_q.size() == 0) begin
          check("read expected", OUTW'(bus.read), '0);
        end else begin
          addr_t a;
          a = addr_q.pop_front();
          check("m_addr", OUTW'(bus.m_addr), OUTW'(a.m));
          check("n_addr", OUTW'(bus.n_addr), OUTW'(a.n));
          check("read cycle", OUTW'(cyc), OUTW'(a.cyc));
          check("q_Read during read", OUTW'(q_read), OUTW'(1'b1));
        end
      end
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          check("done expected", OUTW'(bus.done), '0);
        end else begin
          result_t r;
          r = sb_q.pop_front();
          check("matrix_out", bus.matrix_out, r.out);
          check("err", OUTW'(bus.err), OUTW'(r.err));
          check("done cycle", OUTW'(cyc), OUTW'(r.cyc));
          check("q_Done at done", OUTW'(q_done), OUTW'(1'b1));
        end
      end
    end
  end

  task automatic wait_idle();
    int i;
    i = 0;
    while (!q_idle && i < 200) begin
      @(negedge clk);
      i++;
    end
    if (!q_idle) check("idle reached", OUTW'(q_idle), OUTW'(1'b1));
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    check("job completes", OUTW'(sb_q.size()), '0);
  endtask

  // Issues one request in an Idle cycle and queues its expected reads and result.
  task automatic issue(input int m, input int n, input logic [OUTW-1:0] exp_out);
    int    e0;
    bit    ok;
    result_t r;
    wait_idle();
    bus.m_dim = 8'(m);
    bus.n_dim = 8'(n);
    bus.start = 1'b1;
    e0 = cyc + 1;
    ok = (m > 0) && (n > 0) && (m <= MAX_DIM) && (n <= MAX_DIM);
    if (ok) begin
      for (int i = 0; i < m; i++) begin
        for (int j = 0; j < n; j++) begin
          addr_q.push_back('{m: 8'(i), n: 8'(j), cyc: e0 + i * n + j});
        end
      end
      r = '{out: exp_out, err: 1'b0, cyc: e0 + m * n + 1};
    end else begin
      r = '{out: exp_out, err: 1'b1, cyc: e0};
    end
    sb_q.push_back(r);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic load_3x2();
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 2; j++)
        mem[i][j] = DATA_W'(i * 2 + j + 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [OUTW-1:0] exp_3x2;
    logic [OUTW-1:0] exp;

    cyc = 0;
    n_vec = 0;
    n_miss = 0;
    bus.start = 1'b0;
    bus.m_dim = 8'd0;
    bus.n_dim = 8'd0;
    for (int i = 0; i < MAX_DIM; i++)
      for (int j = 0; j < MAX_DIM; j++)
        mem[i][j] = '0;

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset read", OUTW'(bus.read), '0);
    check("reset m_addr", OUTW'(bus.m_addr), '0);
    check("reset n_addr", OUTW'(bus.n_addr), '0);
    check("reset matrix_out", bus.matrix_out, '0);
    check("reset done", OUTW'(bus.done), '0);
    check("reset err", OUTW'(bus.err), '0);
    check("reset q_Idle", OUTW'(q_idle), OUTW'(1'b1));
    check("reset q_Read", OUTW'(q_read), '0);
    check("reset q_Drain", OUTW'(q_drain), '0);
    check("reset q_Done", OUTW'(q_done), '0);
    reset = 1'b0;
    @(negedge clk);

    // 3x2 normal read of 1..6.
    load_3x2();
    exp_3x2 = '0;
    exp_3x2[191:0] = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    issue(3, 2, exp_3x2);
    wait_drain();

    // Same read with a busy start pulse and a dimension change mid-read.
    issue(3, 2, exp_3x2);
    @(negedge clk);
    bus.start = 1'b1;
    bus.m_dim = 8'd5;
    bus.n_dim = 8'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();

    // Rejected requests leave matrix_out untouched.
    issue(0, 4, exp_3x2);
    wait_drain();
    issue(5, 2, exp_3x2);
    wait_drain();
    issue(3, 0, exp_3x2);
    wait_drain();
    @(negedge clk);
    @(negedge clk);
    check("err held in idle", OUTW'(bus.err), OUTW'(1'b1));
    check("idle after reject", OUTW'(q_idle), OUTW'(1'b1));

    // 1x1 read; stale entries from the 3x2 are cleared.
    mem[0][0] = 32'hDEADBEEF;
    exp = '0;
    exp[31:0] = 32'hDEADBEEF;
    issue(1, 1, exp);
    wait_drain();

    // Largest supported matrix.
    exp = '0;
    for (int i = 0; i < MAX_DIM; i++)
      for (int j = 0; j < MAX_DIM; j++)
        mem[i][j] = 32'h100 + DATA_W'(i * MAX_DIM + j);
    for (int k = 0; k < MAX_DIM * MAX_DIM; k++)
      exp[k*DATA_W +: DATA_W] = 32'h100 + DATA_W'(k);
    issue(MAX_DIM, MAX_DIM, exp);
    wait_drain();

    // Reset after three reads.
    issue(3, 2, '0);
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    addr_q.delete();
    sb_q.delete();
    #1;
    check("midreset read", OUTW'(bus.read), '0);
    check("midreset m_addr", OUTW'(bus.m_addr), '0);
    check("midreset n_addr", OUTW'(bus.n_addr), '0);
    check("midreset matrix_out", bus.matrix_out, '0);
    check("midreset done", OUTW'(bus.done), '0);
    check("midreset q_Idle", OUTW'(q_idle), OUTW'(1'b1));
    check("midreset q_Read", OUTW'(q_read), '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post-reset matrix_out", bus.matrix_out, '0);
    mem[0][0] = 32'h11;
    mem[0][1] = 32'h22;
    mem[1][0] = 32'h33;
    mem[1][1] = 32'h44;
    exp = '0;
    exp[127:0] = {32'h44, 32'h33, 32'h22, 32'h11};
    issue(2, 2, exp);
    wait_drain();

    // Back-to-back: 3x2 then 2x1 of {9,8} issued in the first Idle cycle.
    load_3x2();
    issue(3, 2, exp_3x2);
    wait_drain();
    mem[0][0] = 32'd9;
    mem[1][0] = 32'd8;
    exp = '0;
    exp[63:0] = {32'd8, 32'd9};
    issue(2, 1, exp);
    wait_drain();

    repeat (3) @(negedge clk);
    check("no reads left", OUTW'(addr_q.size()), '0);
    check("no results left", OUTW'(sb_q.size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
